// File: rtl/pipe_pkg.sv
// Shared definitions for the skid-buffered pipeline stage: occupancy states,
// default payload/counter widths and a state-to-occupancy helper.
package pipe_pkg;

    // Default payload width: one bundle such as IR/Pc4/Pc/operands
    localparam int DEFAULT_WIDTH = 128;

    // Default width of the back-pressure (stall) counter
    localparam int DEFAULT_CNT_W = 16;

    // Number of entries held by the stage, encoded directly as the state
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } skid_state_t;

    // Translate a state into the number of payloads currently held
    function automatic logic [1:0] occupancy_of(input skid_state_t state);
        logic [1:0] occ;
        occ = 2'd0;
        case (state)
            EMPTY:   occ = 2'd0;
            ONE:     occ = 2'd1;
            TWO:     occ = 2'd2;
            default: occ = 2'd0;
        endcase
        return occ;
    endfunction

    // True when the state leaves room for another payload
    function automatic logic has_room(input skid_state_t state);
        return (state != TWO);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with asynchronous active-high reset. Counts one per
// rising edge while inc is high and sticks at its all-ones maximum.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic at_max;

    // Saturation detect: the counter must never wrap back to zero
    always_comb begin
        at_max = (count == {WIDTH{1'b1}});
    end

    // Count register: cleared by reset, advanced only below the maximum
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (inc && !at_max) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/pipe_skid_stage.sv
// Two-entry skid-buffered pipeline register. The main entry drives Out_Data
// and the skid entry absorbs the one payload that can arrive while downstream
// stalls, so In_Ready can be a flop with no path from Out_Ready. Flush empties
// both entries; a stall counter records back-pressured cycles.
module pipe_skid_stage
    import pipe_pkg::*;
#(
    parameter int               WIDTH       = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] CLEAR_VALUE = '0,
    parameter int               CNT_W       = DEFAULT_CNT_W
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             In_Valid,
    output logic             In_Ready,
    input  logic [WIDTH-1:0] In_Data,
    input  logic             Flush,
    output logic             Out_Valid,
    input  logic             Out_Ready,
    output logic [WIDTH-1:0] Out_Data,
    output logic [1:0]       Occupancy,
    output logic [CNT_W-1:0] Stall_Cycles
);

    skid_state_t      state;
    skid_state_t      state_next;
    logic [WIDTH-1:0] main_data;
    logic [WIDTH-1:0] main_next;
    logic [WIDTH-1:0] skid_data;
    logic [WIDTH-1:0] skid_next;
    logic             in_ready_q;
    logic             in_ready_next;
    logic             in_xfer;
    logic             out_xfer;
    logic             stalled;

    // Handshake decode: a flushed input is never accepted, while an output
    // handshake in a flush cycle still counts as delivered downstream
    always_comb begin
        in_xfer  = In_Valid && in_ready_q && !Flush;
        out_xfer = Out_Valid && Out_Ready;
        stalled  = Out_Valid && !Out_Ready;
    end

    // Next-state and next-contents logic; held payloads stay put unless an
    // explicit transfer moves them, and Flush overrides everything
    always_comb begin
        state_next = state;
        main_next  = main_data;
        skid_next  = skid_data;

        case (state)
            EMPTY: begin
                if (in_xfer) begin
                    state_next = ONE;
                    main_next  = In_Data;
                end
            end
            ONE: begin
                if (in_xfer && out_xfer) begin
                    state_next = ONE;
                    main_next  = In_Data;
                end else if (in_xfer) begin
                    state_next = TWO;
                    skid_next  = In_Data;
                end else if (out_xfer) begin
                    state_next = EMPTY;
                    main_next  = CLEAR_VALUE;
                end
            end
            TWO: begin
                if (out_xfer) begin
                    state_next = ONE;
                    main_next  = skid_data;
                    skid_next  = CLEAR_VALUE;
                end
            end
            default: begin
                state_next = EMPTY;
                main_next  = CLEAR_VALUE;
                skid_next  = CLEAR_VALUE;
            end
        endcase

        if (Flush) begin
            state_next = EMPTY;
            main_next  = CLEAR_VALUE;
            skid_next  = CLEAR_VALUE;
        end

        in_ready_next = has_room(state_next);
    end

    // State and payload registers; reset discards both entries immediately
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state      <= EMPTY;
            main_data  <= CLEAR_VALUE;
            skid_data  <= CLEAR_VALUE;
            in_ready_q <= 1'b1;
        end else begin
            state      <= state_next;
            main_data  <= main_next;
            skid_data  <= skid_next;
            in_ready_q <= in_ready_next;
        end
    end

    // Outputs are decoded from registers only
    always_comb begin
        In_Ready  = in_ready_q;
        Out_Valid = (state != EMPTY);
        Out_Data  = main_data;
        Occupancy = occupancy_of(state);
    end

    sat_counter #(
        .WIDTH(CNT_W)
    ) u_stall_counter (
        .clock(Clock),
        .reset(Reset),
        .inc  (stalled),
        .count(Stall_Cycles)
    );

endmodule

// File: doc/pipe_skid_stage.md
PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

Interface
REQ-001 Parameter WIDTH, default 128, payload width in bits (one bundle such as IR/Pc4/Pc/operands).
REQ-002 Parameter CLEAR_VALUE, default all-zero WIDTH-bit value, the bubble/NOP payload.
REQ-003 Parameter CNT_W, default 16, stall-counter width.
REQ-004 Clock  input  1  sole clock, rising-edge active.
REQ-005 Reset  input  1  asynchronous, active-high reset.
REQ-006 In_Valid  input  1  upstream payload valid.
REQ-007 In_Ready  output  1  stage can accept this cycle.
REQ-008 In_Data  input  WIDTH  upstream payload.
REQ-009 Flush  input  1  synchronous kill of all held payloads.
REQ-010 Out_Valid  output  1  Out_Data holds a live payload.
REQ-011 Out_Ready  input  1  downstream accepts this cycle.
REQ-012 Out_Data  output  WIDTH  registered payload.
REQ-013 Occupancy  output  2  entries held (0, 1 or 2).
REQ-014 Stall_Cycles  output  CNT_W  saturating count of back-pressured cycles.

Function
REQ-015 Input transfer SHALL occur on a rising edge where In_Valid && In_Ready && !Flush; output transfer where Out_Valid && Out_Ready.
REQ-016 Latency SHALL be exactly 1 cycle: a payload accepted into an empty stage appears on Out_Data with Out_Valid=1 after that edge.
REQ-017 Stage SHALL hold a main entry (drives Out_Data) and a skid entry; three states: EMPTY (0 entries), ONE (main only), TWO (main+skid).
REQ-018 In_Ready SHALL be a registered signal, 1 in EMPTY and ONE, 0 in TWO; no combinational path from Out_Ready to In_Ready.
REQ-019 EMPTY: on input transfer -> ONE, main <= In_Data; otherwise stay.
REQ-020 ONE: input and output transfer -> ONE, main <= In_Data; input only -> TWO, skid <= In_Data; output only -> EMPTY, main <= CLEAR_VALUE; neither -> stay.
REQ-021 TWO: output transfer -> ONE, main <= skid, skid <= CLEAR_VALUE; otherwise stay, contents unchanged.
REQ-022 Out_Valid SHALL be 1 exactly in ONE and TWO; in EMPTY Out_Data SHALL equal CLEAR_VALUE.
REQ-023 Out_Data and held payloads SHALL NOT change while Out_Valid && !Out_Ready, except by Flush.
REQ-024 Flush SHALL override all transitions: next state EMPTY, main and skid <= CLEAR_VALUE; an input offered in the same cycle is dropped; an output transfer in the same cycle counts as delivered.
REQ-025 Occupancy SHALL equal 0/1/2 for EMPTY/ONE/TWO.
REQ-026 Stall_Cycles SHALL increment by 1 on each edge where Out_Valid && !Out_Ready, saturate at 2^CNT_W-1, and be unaffected by Flush.
REQ-027 No payload SHALL be duplicated, reordered or lost except by Flush.

Reset
REQ-028 Reset asserted SHALL immediately force state EMPTY, main and skid = CLEAR_VALUE, In_Ready=1, Out_Valid=0, Occupancy=0, Stall_Cycles=0, independent of Clock.
REQ-029 Reset mid-operation SHALL discard both entries; the first edge after release behaves as EMPTY.

Structure
REQ-030 Shared package pipe_pkg SHALL hold the state enumeration typedef (EMPTY/ONE/TWO) and default WIDTH and CNT_W constants.
REQ-031 Stall counter SHALL be a separate sub-module sat_counter (parameter width, inputs inc and async reset); all else is one module.

Verification
REQ-032 Reset, then In_Data=0x11 valid one cycle, Out_Ready=1 -> next cycle Out_Valid=1, Out_Data=0x11, Occupancy=1; following cycle Out_Data=CLEAR_VALUE, Out_Valid=0.
REQ-033 Out_Ready=0, push 0xA then 0xB -> Occupancy=2, In_Ready=0, Out_Data=0xA; raise Out_Ready -> 0xA, 0xB delivered in order on consecutive cycles.
REQ-034 Stage in TWO, assert Flush with In_Valid=1, In_Data=0xC -> next cycle Occupancy=0, Out_Valid=0, Out_Data=CLEAR_VALUE, 0xC never appears.
REQ-035 CNT_W=3, Out_Valid=1, Out_Ready=0 for 10 cycles -> Stall_Cycles 1..7 then holds 7.
REQ-036 Random In_Valid/Out_Ready 10000 cycles, 1000 payloads -> scoreboard output stream equals input stream, In_Ready never 1 in TWO.
REQ-037 Assert Reset between edges while Occupancy=2 -> outputs reach reset values before next edge; no stale payload after release.
